// File: rtl/fx3_bus_out_packer_pkg.sv
// Shared definitions for the FX3 outbound packer: header length and word
// order, FSM state encoding, and header word selection.
package fx3_bus_out_packer_pkg;

    // Number of header words written ahead of the read data.
    localparam int unsigned STATUS_LENGTH = 3;

    // Header word positions.
    localparam logic [1:0] HDR_FLAGS = 2'd0;
    localparam logic [1:0] HDR_SIZE  = 2'd1;
    localparam logic [1:0] HDR_ADDR  = 2'd2;

    // Header index value once every header word has been written.
    localparam logic [1:0] HDR_DONE = 2'(STATUS_LENGTH);

    // Header length widened to the 33-bit total word counter.
    localparam logic [32:0] STATUS_LENGTH_W = 33'(STATUS_LENGTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_HEADER  = 3'd2,
        ST_DATA    = 3'd3,
        ST_FLUSH   = 3'd4
    } packer_state_e;

    // Select the header word for a given header position.
    function automatic logic [31:0] header_word(
        input logic [1:0]  idx,
        input logic [31:0] flags,
        input logic [31:0] size,
        input logic [31:0] addr
    );
        case (idx)
            HDR_FLAGS: return flags;
            HDR_SIZE:  return size;
            HDR_ADDR:  return addr;
            default:   return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/fx3_bus_out_packer_arbiter.sv
// fx3_wpath_arbiter: write-side ownership of a ping-pong FIFO. Picks a ready
// buffer (bit 0 preferred), holds the activate register, counts words written
// into the owned buffer and reports room/full against the buffer capacity.
module fx3_wpath_arbiter
    import fx3_bus_out_packer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        acquire_i,
    input  logic        release_i,
    input  logic        write_i,
    input  logic [1:0]  wpath_ready_i,
    input  logic [23:0] wpath_size_i,
    output logic [1:0]  activate_o,
    output logic        granted_o,
    output logic        space_o,
    output logic        full_o
);

    logic [1:0]  activate_q;
    logic [1:0]  activate_d;
    logic [23:0] buf_count_q;
    logic [23:0] buf_count_d;
    logic        owned_s;

    assign owned_s    = (activate_q != 2'b00);
    assign granted_o  = acquire_i && !owned_s && (wpath_ready_i != 2'b00);
    assign space_o    = owned_s && (buf_count_q < wpath_size_i);
    assign full_o     = owned_s && !(buf_count_q < wpath_size_i);
    assign activate_o = activate_q;

    // Next ownership and fill level: release wins, then a new grant, then writes.
    always_comb begin
        activate_d  = activate_q;
        buf_count_d = buf_count_q;
        if (release_i) begin
            activate_d = 2'b00;
        end else if (granted_o) begin
            activate_d  = wpath_ready_i[0] ? 2'b01 : 2'b10;
            buf_count_d = 24'd0;
        end else if (write_i) begin
            buf_count_d = buf_count_q + 24'd1;
        end else begin
            activate_d = activate_q;
        end
    end

    // Ownership and fill-level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            activate_q  <= 2'b00;
            buf_count_q <= 24'd0;
        end else begin
            activate_q  <= activate_d;
            buf_count_q <= buf_count_d;
        end
    end

endmodule

// File: rtl/fx3_bus_out_packer.sv
// fx3_bus_out_packer: latches a completed-command status, announces it to the
// out path, then writes a 3-word header plus the read data into the write side
// of the out-path ping-pong FIFO, spilling across buffers when one fills.
// Optional data watchdog: define FX3_OUT_PACKER_TIMEOUT_EN to pad stalled
// transfers with PAD_WORD after TIMEOUT_CYCLES idle cycles.
module fx3_bus_out_packer
    import fx3_bus_out_packer_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1024,
    parameter logic [31:0] PAD_WORD       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_status_stb,
    input  logic [31:0] i_status_flags,
    input  logic [31:0] i_read_size,
    input  logic [31:0] i_status_address,
    output logic        o_busy,
    input  logic        i_data_stb,
    input  logic [31:0] i_data,
    output logic        o_data_ready,
    output logic        o_status_rdy_stb,
    output logic [31:0] o_read_size,
    input  logic [1:0]  i_wpath_ready,
    output logic [1:0]  o_wpath_activate,
    input  logic [23:0] i_wpath_size,
    output logic        o_wpath_strobe,
    output logic [31:0] o_wpath_data,
    output logic        o_done,
    output logic        o_timeout
);

    packer_state_e state_q;
    logic [31:0]   flags_q;
    logic [31:0]   read_size_q;
    logic [31:0]   addr_q;
    logic [32:0]   words_left_q;
    logic [1:0]    hdr_idx_q;
    logic          busy_q;
    logic          status_rdy_q;
    logic          strobe_q;
    logic [31:0]   wdata_q;
    logic          done_q;

    logic          granted_s;
    logic          space_s;
    logic          full_s;
    logic          acquire_s;
    logic          release_s;
    logic          hdr_write_s;
    logic          room_s;
    logic          data_write_s;
    logic          timeout_s;

    assign acquire_s    = (state_q == ST_ACQUIRE);
    assign release_s    = (state_q == ST_FLUSH) ||
                          (((state_q == ST_HEADER) || (state_q == ST_DATA)) && full_s);
    assign hdr_write_s  = (state_q == ST_HEADER) && space_s;
    assign room_s       = (state_q == ST_DATA) && space_s && (words_left_q != 33'd0);
    // Once timed out the upstream is no longer offered a slot; pad words fill it.
    assign data_write_s = room_s && (i_data_stb || timeout_s);

    fx3_wpath_arbiter u_arbiter (
        .clk           (clk),
        .rst           (rst),
        .acquire_i     (acquire_s),
        .release_i     (release_s),
        .write_i       (hdr_write_s || data_write_s),
        .wpath_ready_i (i_wpath_ready),
        .wpath_size_i  (i_wpath_size),
        .activate_o    (o_wpath_activate),
        .granted_o     (granted_s),
        .space_o       (space_s),
        .full_o        (full_s)
    );

`ifdef FX3_OUT_PACKER_TIMEOUT_EN
    logic [23:0] stall_q;
    logic        timeout_q;

    // Watchdog: count consecutive stalled cycles in DATA and latch a sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q   <= 24'd0;
            timeout_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && i_status_stb) begin
            stall_q   <= 24'd0;
            timeout_q <= 1'b0;
        end else if (data_write_s) begin
            stall_q <= 24'd0;
        end else if (o_data_ready && !i_data_stb) begin
            stall_q <= stall_q + 24'd1;
            if ((stall_q + 24'd1) >= TIMEOUT_CYCLES) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_s = timeout_q;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^TIMEOUT_CYCLES;
    assign timeout_s    = 1'b0;
`endif

    assign o_data_ready     = room_s && !timeout_s;
    assign o_busy           = busy_q;
    assign o_status_rdy_stb = status_rdy_q;
    assign o_read_size      = read_size_q;
    assign o_wpath_strobe   = strobe_q;
    assign o_wpath_data     = wdata_q;
    assign o_done           = done_q;
    assign o_timeout        = timeout_s;

    // Packer FSM: latch status, own a buffer, write header then data, release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            flags_q      <= 32'd0;
            read_size_q  <= 32'd0;
            addr_q       <= 32'd0;
            words_left_q <= 33'd0;
            hdr_idx_q    <= 2'd0;
            busy_q       <= 1'b0;
            status_rdy_q <= 1'b0;
            strobe_q     <= 1'b0;
            wdata_q      <= 32'd0;
            done_q       <= 1'b0;
        end else begin
            status_rdy_q <= 1'b0;
            strobe_q     <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_status_stb) begin
                        flags_q      <= i_status_flags;
                        read_size_q  <= i_read_size;
                        addr_q       <= i_status_address;
                        words_left_q <= {1'b0, i_read_size} + STATUS_LENGTH_W;
                        hdr_idx_q    <= 2'd0;
                        busy_q       <= 1'b1;
                        status_rdy_q <= 1'b1;
                        state_q      <= ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (granted_s) begin
                        state_q <= (hdr_idx_q != HDR_DONE) ? ST_HEADER : ST_DATA;
                    end
                end
                ST_HEADER: begin
                    if (hdr_write_s) begin
                        strobe_q     <= 1'b1;
                        wdata_q      <= header_word(hdr_idx_q, flags_q, read_size_q, addr_q);
                        words_left_q <= words_left_q - 33'd1;
                        hdr_idx_q    <= hdr_idx_q + 2'd1;
                        if (hdr_idx_q == HDR_ADDR) begin
                            state_q <= (read_size_q == 32'd0) ? ST_FLUSH : ST_DATA;
                        end
                    end else if (full_s) begin
                        state_q <= ST_ACQUIRE;
                    end
                end
                ST_DATA: begin
                    if (data_write_s) begin
                        strobe_q     <= 1'b1;
                        wdata_q      <= timeout_s ? PAD_WORD : i_data;
                        words_left_q <= words_left_q - 33'd1;
                        if (words_left_q == 33'd1) begin
                            state_q <= ST_FLUSH;
                        end
                    end else if (full_s) begin
                        state_q <= ST_ACQUIRE;
                    end
                end
                ST_FLUSH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fx3_bus_out_packer.sv
// Directed bench for fx3_bus_out_packer: header/data ordering, zero-length
// reads, buffer spills, buffer selection, ignored status, mid-transfer reset,
// and (with FX3_OUT_PACKER_TIMEOUT_EN) the padding watchdog.
module tb_fx3_bus_out_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_status_stb;
    logic [31:0] i_status_flags;
    logic [31:0] i_read_size;
    logic [31:0] i_status_address;
    logic        o_busy;
    logic        i_data_stb;
    logic [31:0] i_data;
    logic        o_data_ready;
    logic        o_status_rdy_stb;
    logic [31:0] o_read_size;
    logic [1:0]  i_wpath_ready;
    logic [1:0]  o_wpath_activate;
    logic [23:0] i_wpath_size;
    logic        o_wpath_strobe;
    logic [31:0] o_wpath_data;
    logic        o_done;
    logic        o_timeout;

    fx3_bus_out_packer #(
        .TIMEOUT_CYCLES (24'd16),
        .PAD_WORD       (32'hDEADBEEF)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_status_stb     (i_status_stb),
        .i_status_flags   (i_status_flags),
        .i_read_size      (i_read_size),
        .i_status_address (i_status_address),
        .o_busy           (o_busy),
        .i_data_stb       (i_data_stb),
        .i_data           (i_data),
        .o_data_ready     (o_data_ready),
        .o_status_rdy_stb (o_status_rdy_stb),
        .o_read_size      (o_read_size),
        .i_wpath_ready    (i_wpath_ready),
        .o_wpath_activate (o_wpath_activate),
        .i_wpath_size     (i_wpath_size),
        .o_wpath_strobe   (o_wpath_strobe),
        .o_wpath_data     (o_wpath_data),
        .o_done           (o_done),
        .o_timeout        (o_timeout)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  win_act[$];
    int          win_len[$];
    int          win_cnt, n_strobes, done_cnt, rdy_cnt, data_idx, feed_limit;
    bit          done_seen, done_at_fall, dr_seen, pp_mode, feed_en, prev_xfer;
    logic [1:0]  prev_act;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive the next inputs.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (prev_xfer) data_idx++;
        if (o_wpath_strobe) begin
            win_cnt++;
            n_strobes++;
            chk("strobe_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wdata", o_wpath_data, e);
            end
        end
        if (o_data_ready) dr_seen = 1'b1;
        if (o_status_rdy_stb) rdy_cnt++;
        if (o_done) begin
            done_cnt++;
            done_seen = 1'b1;
            if ((o_wpath_activate == 2'b00) && (prev_act != 2'b00)) done_at_fall = 1'b1;
        end
        if ((prev_act != 2'b00) && (o_wpath_activate != prev_act)) begin
            win_act.push_back(prev_act);
            win_len.push_back(win_cnt);
            win_cnt = 0;
            if (pp_mode && (o_wpath_activate == 2'b00)) i_wpath_ready = ~prev_act;
        end
        prev_act   = o_wpath_activate;
        i_data_stb = feed_en && (data_idx < feed_limit);
        i_data     = 32'hA000_0000 + 32'(data_idx);
        prev_xfer  = i_data_stb && o_data_ready;
    endtask

    task automatic clear_rec();
        exp_q.delete();
        win_act.delete();
        win_len.delete();
        win_cnt = 0; n_strobes = 0; done_cnt = 0; rdy_cnt = 0; data_idx = 0;
        done_seen = 1'b0; done_at_fall = 1'b0; dr_seen = 1'b0; prev_xfer = 1'b0;
    endtask

    task automatic load_expected(input logic [31:0] f, input logic [31:0] sz,
                                 input logic [31:0] a, input int n_real, input int n_pad);
        exp_q.push_back(f);
        exp_q.push_back(sz);
        exp_q.push_back(a);
        for (int k = 0; k < n_real; k++) exp_q.push_back(32'hA000_0000 + 32'(k));
        for (int k = 0; k < n_pad; k++) exp_q.push_back(32'hDEADBEEF);
    endtask

    task automatic start_status(input logic [31:0] f, input logic [31:0] sz, input logic [31:0] a);
        i_status_stb     = 1'b1;
        i_status_flags   = f;
        i_read_size      = sz;
        i_status_address = a;
        tick();
        i_status_stb = 1'b0;
        chk("status_rdy_stb", o_status_rdy_stb, 1'b1);
        chk("read_size", o_read_size, sz);
        chk("busy_on", o_busy, 1'b1);
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        while (!done_seen && (n < budget)) begin
            tick();
            n++;
        end
        chk("done_within_budget", done_seen, 1'b1);
    endtask

    task automatic chk_window(input int i, input logic [1:0] act, input int len);
        chk("window_act", (i < win_act.size()) ? win_act[i] : 2'bxx, act);
        chk("window_len", (i < win_len.size()) ? win_len[i] : -1, len);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_rdy"}, o_status_rdy_stb, 1'b0);
        chk({tag, "_read_size"}, o_read_size, 32'd0);
        chk({tag, "_activate"}, o_wpath_activate, 2'b00);
        chk({tag, "_strobe"}, o_wpath_strobe, 1'b0);
        chk({tag, "_wdata"}, o_wpath_data, 32'd0);
        chk({tag, "_done"}, o_done, 1'b0);
        chk({tag, "_timeout"}, o_timeout, 1'b0);
        chk({tag, "_data_ready"}, o_data_ready, 1'b0);
    endtask

    initial begin
        rst = 1'b1; i_status_stb = 1'b0; i_status_flags = 32'd0; i_read_size = 32'd0;
        i_status_address = 32'd0; i_data_stb = 1'b0; i_data = 32'd0;
        i_wpath_ready = 2'b11; i_wpath_size = 24'd256; prev_act = 2'b00;
        pp_mode = 1'b0; feed_en = 1'b0; feed_limit = 0;
        clear_rec();

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Read size 5, both buffers ready, data every cycle
        clear_rec();
        feed_en = 1'b1; feed_limit = 5;
        load_expected(32'h1111_0001, 32'd5, 32'h2222_0010, 5, 0);
        start_status(32'h1111_0001, 32'd5, 32'h2222_0010);
        tick();
        chk("rdy_one_cycle", o_status_rdy_stb, 1'b0);
        run_to_done(100);
        chk("t1_strobes", n_strobes, 8);
        chk("t1_windows", win_act.size(), 1);
        chk_window(0, 2'b01, 8);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_at_fall", done_at_fall, 1'b1);
        chk("t1_busy_off", o_busy, 1'b0);
        chk("t1_all_consumed", exp_q.size(), 0);
        chk("t1_rdy_cnt", rdy_cnt, 1);
        tick();

        // Read size 0: header only
        clear_rec();
        feed_limit = 0;
        load_expected(32'h3333_0002, 32'd0, 32'h4444_0020, 0, 0);
        start_status(32'h3333_0002, 32'd0, 32'h4444_0020);
        run_to_done(100);
        chk("t2_strobes", n_strobes, 3);
        chk_window(0, 2'b01, 3);
        chk("t2_done_at_fall", done_at_fall, 1'b1);
        chk("t2_data_ready_never", dr_seen, 1'b0);
        tick();

        // Read size 600 across 256-word buffers, ping-pong ready model
        clear_rec();
        pp_mode = 1'b1; feed_limit = 600;
        load_expected(32'h5555_0003, 32'd600, 32'h6666_0030, 600, 0);
        start_status(32'h5555_0003, 32'd600, 32'h6666_0030);
        run_to_done(900);
        chk("t3_strobes", n_strobes, 603);
        chk("t3_windows", win_act.size(), 3);
        chk_window(0, 2'b01, 256);
        chk_window(1, 2'b10, 256);
        chk_window(2, 2'b01, 91);
        chk("t3_all_consumed", exp_q.size(), 0);
        chk("t3_done_cnt", done_cnt, 1);
        pp_mode = 1'b0;
        i_wpath_ready = 2'b11;
        tick();

        // Only buffer 1 ready
        clear_rec();
        i_wpath_ready = 2'b10; feed_limit = 1;
        load_expected(32'h7777_0004, 32'd1, 32'h8888_0040, 1, 0);
        start_status(32'h7777_0004, 32'd1, 32'h8888_0040);
        run_to_done(100);
        chk_window(0, 2'b10, 4);
        chk("t4_all_consumed", exp_q.size(), 0);
        i_wpath_ready = 2'b11;
        tick();

        // Second status mid-transfer is ignored; reset while stalled in DATA
        clear_rec();
        feed_limit = 3;
        load_expected(32'h9999_0005, 32'd20, 32'hAAAA_0050, 3, 0);
        start_status(32'h9999_0005, 32'd20, 32'hAAAA_0050);
        repeat (2) tick();
        i_status_stb = 1'b1; i_status_flags = 32'hBBBB_0006;
        i_read_size = 32'd7; i_status_address = 32'hCCCC_0060;
        tick();
        i_status_stb = 1'b0;
        chk("ignored_rdy", o_status_rdy_stb, 1'b0);
        chk("ignored_size", o_read_size, 32'd20);
        repeat (8) tick();
        chk("t5_stalled_ready", o_data_ready, 1'b1);
        chk("t5_written", n_strobes, 6);
        chk("t5_all_consumed", exp_q.size(), 0);
        chk("t5_rdy_cnt", rdy_cnt, 1);
        rst = 1'b1;
        tick();
        chk_all_zero("midreset");
        rst = 1'b0;
        feed_en = 1'b0;
        tick();

`ifdef FX3_OUT_PACKER_TIMEOUT_EN
        // Upstream stops after 2 of 10 words: watchdog pads the rest
        clear_rec();
        feed_en = 1'b1; feed_limit = 2;
        load_expected(32'hDDDD_0007, 32'd10, 32'hEEEE_0070, 2, 8);
        start_status(32'hDDDD_0007, 32'd10, 32'hEEEE_0070);
        run_to_done(200);
        chk("t6_timeout", o_timeout, 1'b1);
        chk("t6_strobes", n_strobes, 13);
        chk("t6_all_consumed", exp_q.size(), 0);
        tick();
        clear_rec();
        load_expected(32'h0000_0008, 32'd0, 32'h0000_0080, 0, 0);
        start_status(32'h0000_0008, 32'd0, 32'h0000_0080);
        chk("t6_timeout_cleared", o_timeout, 1'b0);
        run_to_done(100);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
